// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per opcode and drives
// datapath strobes and selects combinationally from the current state and opcode.
module multicycle_control_unit #(
  parameter int unsigned OPW    = 6,
  parameter int unsigned ALUOPW = 3,
  parameter int unsigned CNTW   = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              Extsel,
  output logic              RegOut,
  output logic              RegWre,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ALUSrcB,
  output logic              ALUM2Reg,
  output logic              PCSrc,
  output logic              DataMemRd,
  output logic              DataMemWr,
  output logic              Halted,
  output logic              IllegalOp,
  output logic [2:0]        State,
  output logic [CNTW-1:0]   InstrCount
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OpAdd, OpAddi, OpSub, OpOri, OpAnd, OpOr, OpMove, OpSw, OpLw, OpBeq, OpHalt, OpBad
  } op_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q;
  op_e               op_cls;

  logic              alu_srcb, alu_ext;
  logic [ALUOPW-1:0] alu_op;

  logic pc_wre, ir_wre, ext_c, reg_out, reg_wre, srcb_c, m2reg, pc_src;
  logic mem_rd, mem_wr, halted_c, illegal_c;
  logic [ALUOPW-1:0] aluop_c;

  // Any set bit above the 6-bit encoding space makes the opcode illegal.
  always_comb begin
    op_cls = OpBad;
    if ((opcode >> 6) == '0) begin
      case (opcode[5:0])
        6'b000000: op_cls = OpAdd;
        6'b000001: op_cls = OpAddi;
        6'b000010: op_cls = OpSub;
        6'b010000: op_cls = OpOri;
        6'b010001: op_cls = OpAnd;
        6'b010010: op_cls = OpOr;
        6'b100000: op_cls = OpMove;
        6'b100110: op_cls = OpSw;
        6'b100111: op_cls = OpLw;
        6'b110000: op_cls = OpBeq;
        6'b111111: op_cls = OpHalt;
        default:   op_cls = OpBad;
      endcase
    end
  end

  always_comb begin
    alu_op   = '0;
    alu_srcb = 1'b0;
    alu_ext  = 1'b0;
    case (op_cls)
      OpAdd, OpMove: alu_ext = 1'b1;
      OpAddi, OpLw, OpSw: begin
        alu_srcb = 1'b1;
        alu_ext  = 1'b1;
      end
      OpSub: alu_op = ALUOPW'(1);
      OpOri: begin
        alu_op   = ALUOPW'(3);
        alu_srcb = 1'b1;
      end
      OpAnd: alu_op = ALUOPW'(4);
      OpOr:  alu_op = ALUOPW'(3);
      OpBeq: begin
        alu_op  = ALUOPW'(1);
        alu_ext = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = StIf;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    ext_c     = 1'b0;
    reg_out   = 1'b0;
    reg_wre   = 1'b0;
    aluop_c   = '0;
    srcb_c    = 1'b0;
    m2reg     = 1'b0;
    pc_src    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted_c  = 1'b0;
    illegal_c = 1'b0;
    unique case (state_q)
      StIf: begin
        ir_wre  = 1'b1;
        state_d = StId;
      end
      StId: begin
        if (op_cls == OpHalt) begin
          state_d = StHalt;
        end else if (op_cls == OpBad) begin
          illegal_c = 1'b1;
          pc_wre    = 1'b1;
          state_d   = StIf;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        aluop_c = alu_op;
        srcb_c  = alu_srcb;
        ext_c   = alu_ext;
        case (op_cls)
          OpBeq: begin
            pc_wre  = 1'b1;
            pc_src  = zero;
            state_d = StIf;
          end
          OpLw, OpSw:    state_d = StMem;
          OpHalt, OpBad: state_d = StIf;
          default:       state_d = StWb;
        endcase
      end
      StMem: begin
        aluop_c = alu_op;
        srcb_c  = alu_srcb;
        ext_c   = alu_ext;
        if (op_cls == OpLw) begin
          mem_rd  = 1'b1;
          state_d = StWb;
        end else if (op_cls == OpSw) begin
          mem_wr = 1'b1;
          pc_wre = 1'b1;
        end
      end
      StWb: begin
        aluop_c = alu_op;
        srcb_c  = alu_srcb;
        ext_c   = alu_ext;
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        reg_out = (op_cls == OpAdd) || (op_cls == OpSub) || (op_cls == OpAnd) ||
                  (op_cls == OpOr) || (op_cls == OpMove);
        m2reg   = (op_cls == OpLw);
        mem_rd  = (op_cls == OpLw);
      end
      StHalt: begin
        halted_c = 1'b1;
        state_d  = StHalt;
      end
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_wre) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  // Reset masks every output so nothing is written in the reset cycle.
  assign PCWre      = pc_wre & ~Reset;
  assign IRWre      = ir_wre & ~Reset;
  assign InsMemRW   = 1'b0;
  assign Extsel     = ext_c & ~Reset;
  assign RegOut     = reg_out & ~Reset;
  assign RegWre     = reg_wre & ~Reset;
  assign ALUOp      = Reset ? '0 : aluop_c;
  assign ALUSrcB    = srcb_c & ~Reset;
  assign ALUM2Reg   = m2reg & ~Reset;
  assign PCSrc      = pc_src & ~Reset;
  assign DataMemRd  = mem_rd & ~Reset;
  assign DataMemWr  = mem_wr & ~Reset;
  assign Halted     = halted_c & ~Reset;
  assign IllegalOp  = illegal_c & ~Reset;
  assign State      = Reset ? 3'd0 : state_q;
  assign InstrCount = Reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected per-cycle control words are
// queued per instruction and compared against the DUT at each falling edge.
module tb_multicycle_control_unit;
  localparam int unsigned OPW    = 6;
  localparam int unsigned ALUOPW = 3;
  localparam int unsigned CNTW   = 4;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b000111;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic [OPW-1:0]    opcode = '0;
  logic              zero = 1'b0;
  logic              PCWre, IRWre, InsMemRW, Extsel, RegOut, RegWre;
  logic [ALUOPW-1:0] ALUOp;
  logic              ALUSrcB, ALUM2Reg, PCSrc, DataMemRd, DataMemWr, Halted, IllegalOp;
  logic [2:0]        State;
  logic [CNTW-1:0]   InstrCount;

  multicycle_control_unit #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW),
    .CNTW   (CNTW)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .opcode     (opcode),
    .zero       (zero),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .InsMemRW   (InsMemRW),
    .Extsel     (Extsel),
    .RegOut     (RegOut),
    .RegWre     (RegWre),
    .ALUOp      (ALUOp),
    .ALUSrcB    (ALUSrcB),
    .ALUM2Reg   (ALUM2Reg),
    .PCSrc      (PCSrc),
    .DataMemRd  (DataMemRd),
    .DataMemWr  (DataMemWr),
    .Halted     (Halted),
    .IllegalOp  (IllegalOp),
    .State      (State),
    .InstrCount (InstrCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, insmem, ext, regout, regwre;
    logic [2:0] aluop;
    logic       srcb, m2r, pcsrc, rd, wr, halted, ill;
  } ctl_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [CNTW-1:0] cnt;
  } exp_t;

  ctl_t            obs;
  exp_t            sb_q[$];
  logic [CNTW-1:0] m_cnt = '0;
  int              n_checks = 0;
  int              n_fails = 0;

  assign obs = {State, PCWre, IRWre, InsMemRW, Extsel, RegOut, RegWre, ALUOp, ALUSrcB,
                ALUM2Reg, PCSrc, DataMemRd, DataMemWr, Halted, IllegalOp};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Expected control word for one cycle, written straight from the opcode table.
  task automatic push_state(input logic [5:0] op, input logic [2:0] st, input logic z);
    ctl_t c;
    logic rtype;
    c = '0;
    c.st = st;
    rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
            (op == OP_MOVE);
    if (st >= 3'd2 && st <= 3'd4) begin
      if (op == OP_ADD || op == OP_MOVE)                  begin c.aluop = 3'd0; c.ext = 1'b1; end
      if (op == OP_ADDI || op == OP_LW || op == OP_SW)    begin c.srcb = 1'b1; c.ext = 1'b1; end
      if (op == OP_SUB)                                   c.aluop = 3'd1;
      if (op == OP_ORI)                                   begin c.aluop = 3'd3; c.srcb = 1'b1; end
      if (op == OP_AND)                                   c.aluop = 3'd4;
      if (op == OP_OR)                                    c.aluop = 3'd3;
      if (op == OP_BEQ)                                   begin c.aluop = 3'd1; c.ext = 1'b1; end
    end
    if (st == 3'd0) c.irwre = 1'b1;
    if (st == 3'd1 && op == OP_BAD) begin c.ill = 1'b1; c.pcwre = 1'b1; end
    if (st == 3'd2 && op == OP_BEQ) begin c.pcwre = 1'b1; c.pcsrc = z; end
    if (st == 3'd3 && op == OP_LW) c.rd = 1'b1;
    if (st == 3'd3 && op == OP_SW) begin c.wr = 1'b1; c.pcwre = 1'b1; end
    if (st == 3'd4) begin
      c.regwre = 1'b1;
      c.pcwre  = 1'b1;
      c.regout = rtype;
      c.m2r    = (op == OP_LW);
      c.rd     = (op == OP_LW);
    end
    if (st == 3'd5) c.halted = 1'b1;
    sb_q.push_back('{ctl: c, cnt: m_cnt});
    if (c.pcwre) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic push_reset();
    sb_q.push_back('{ctl: '0, cnt: '0});
    m_cnt = '0;
  endtask

  // One clock: drive after the rising edge, compare at the falling edge.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic z, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset  = rst;
    opcode = op;
    zero   = z;
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      check_val({tag, " scoreboard-empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, " ctl"}, 32'(obs), 32'(e.ctl));
      check_val({tag, " cnt"}, 32'(InstrCount), 32'(e.cnt));
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zexe, input string name);
    int n;
    push_state(op, 3'd0, zexe);
    push_state(op, 3'd1, zexe);
    n = 2;
    if (op != OP_BAD) begin
      push_state(op, 3'd2, zexe);
      n++;
      if (op == OP_LW) begin
        push_state(op, 3'd3, zexe);
        push_state(op, 3'd4, zexe);
        n += 2;
      end else if (op == OP_SW) begin
        push_state(op, 3'd3, zexe);
        n++;
      end else if (op != OP_BEQ) begin
        push_state(op, 3'd4, zexe);
        n++;
      end
    end
    // zero only matters in EXE; drive the opposite value elsewhere as noise.
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, op, (i == 2) ? zexe : ~zexe, $sformatf("%s c%0d", name, i));
    end
  endtask

  initial begin
    push_reset();
    push_reset();
    cyc(1'b1, OP_ADD, 1'b0, "reset0");
    cyc(1'b1, OP_ADD, 1'b1, "reset1");

    run_instr(OP_ADD,  1'b0, "add");
    run_instr(OP_LW,   1'b1, "lw");
    run_instr(OP_BEQ,  1'b1, "beq_z1");
    run_instr(OP_BEQ,  1'b0, "beq_z0");
    run_instr(OP_ORI,  1'b0, "ori");
    run_instr(OP_BAD,  1'b0, "illegal");
    run_instr(OP_SUB,  1'b1, "sub");
    run_instr(OP_AND,  1'b0, "and");
    run_instr(OP_OR,   1'b1, "or");
    run_instr(OP_MOVE, 1'b0, "move");
    run_instr(OP_ADDI, 1'b1, "addi");
    run_instr(OP_SW,   1'b0, "sw");

    // Reset lands in the MEM cycle of a store: no write strobe may escape.
    push_state(OP_SW, 3'd0, 1'b0);
    push_state(OP_SW, 3'd1, 1'b0);
    push_state(OP_SW, 3'd2, 1'b0);
    push_reset();
    cyc(1'b0, OP_SW, 1'b0, "swrst c0");
    cyc(1'b0, OP_SW, 1'b0, "swrst c1");
    cyc(1'b0, OP_SW, 1'b0, "swrst c2");
    cyc(1'b1, OP_SW, 1'b0, "swrst mem");

    // Sixteen retirements on a 4-bit counter wrap it back to zero.
    for (int k = 0; k < 16; k++) begin
      run_instr(OP_ADD, k[0], $sformatf("wrap%0d", k));
    end
    check_val("wrap model", 32'(m_cnt), 32'd0);
    run_instr(OP_MOVE, 1'b1, "after_wrap");

    push_state(OP_HALT, 3'd0, 1'b0);
    push_state(OP_HALT, 3'd1, 1'b0);
    for (int k = 0; k < 10; k++) push_state(OP_HALT, 3'd5, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, OP_HALT, k[0], $sformatf("halt c%0d", k));
    end
    push_reset();
    cyc(1'b1, OP_HALT, 1'b0, "halt reset");
    run_instr(OP_ADD, 1'b0, "post_halt");

    check_val("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle control unit for the next-generation CPU datapath. It sequences each instruction through IF/ID/EXE/MEM/WB states instead of decoding in one combinational step. It drives per-state write enables and mux selects to the PC, instruction register, register file, ALU and data memory. It also reports halt, illegal-opcode and retired-instruction status.

## Interface
Parameters:
- OPW, 6, opcode width; encodings below occupy the low 6 bits, upper bits must be 0.
- ALUOPW, 3, ALU operation code width.
- CNTW, 16, retired-instruction counter width.

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- opcode  in  OPW  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction register load enable.
- InsMemRW  out  1  always 0 (read).
- Extsel  out  1  1 = sign-extend immediate, 0 = zero-extend.
- RegOut  out  1  destination select, 0 = rt, 1 = rd.
- RegWre  out  1  register file write enable.
- ALUOp  out  ALUOPW  ALU op: 0 add, 1 sub, 3 or, 4 and.
- ALUSrcB  out  1  0 = register, 1 = extended immediate.
- ALUM2Reg  out  1  write-back source, 1 = data memory.
- PCSrc  out  1  1 = branch target.
- DataMemRd  out  1  data memory read strobe.
- DataMemWr  out  1  data memory write strobe.
- Halted  out  1  FSM is in HALT.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- State  out  3  current state, for debug.
- InstrCount  out  CNTW  retired-instruction count.

## Operation
- Opcodes: add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, move 100000, sw 100110, lw 100111, beq 110000, halt 111111. All others are illegal.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to IF on the next edge.
- IF: IRWre=1. Next state is ID.
- ID:
  - halt goes to HALT.
  - An illegal opcode asserts IllegalOp and PCWre (skips the instruction), then goes to IF.
  - All other opcodes go to EXE.
- EXE: ALUOp, ALUSrcB and Extsel are driven per opcode.
  - add/move: op 0, SrcB 0, Ext 1.
  - addi: op 0, SrcB 1, Ext 1.
  - sub: op 1, SrcB 0.
  - ori: op 3, SrcB 1, Ext 0.
  - and: op 4, SrcB 0.
  - or: op 3, SrcB 0.
  - lw/sw: op 0, SrcB 1, Ext 1.
  - beq: op 1, SrcB 0, Ext 1, PCWre=1, PCSrc=zero, then goes to IF.
  - lw/sw go to MEM. All others go to WB.
- MEM:
  - ALU controls are held from EXE.
  - lw: DataMemRd=1, then goes to WB.
  - sw: DataMemWr=1 and PCWre=1, then goes to IF.
- WB:
  - ALU controls are held.
  - RegWre=1 and PCWre=1.
  - RegOut=1 for add/sub/and/or/move, 0 for addi/ori/lw.
  - ALUM2Reg=1 for lw only (DataMemRd also held at 1).
  - Next state is IF.
- HALT: all strobes are 0 and Halted=1. The FSM stays in HALT until Reset.
- Any signal not listed for a state is 0.
- InstrCount increments by 1 on every edge where PCWre=1 (retire or illegal skip). It wraps from 2^CNTW-1 to 0.

## Timing
- Outputs are combinational from State and opcode; opcode must be stable from ID until the instruction retires.
- Reset:
  - While Reset=1, every output is forced to 0: strobes, selects, ALUOp, Halted, IllegalOp, State and InstrCount.
  - On the edge with Reset=1, State becomes IF and InstrCount becomes 0.
  - The first cycle after release is IF.
  - Reset overrides any state, including HALT or mid-MEM. No write strobe is asserted in the reset cycle.
- Latency in cycles from IF to the next IF:
  - beq: 3
  - add/addi/sub/ori/and/or/move: 4
  - sw: 4
  - lw: 5
  - illegal opcode: 2
- PCWre is high for exactly one cycle per instruction. RegWre, DataMemWr and DataMemRd are never high in the same cycle as IRWre.
- zero is sampled only in EXE for beq. A change of zero in any other state has no effect.

## Test plan
- Reset, then add → State sequence 0,1,2,4,0. RegWre=1 and RegOut=1 only in cycle 4. InstrCount=1.
- lw → sequence 0,1,2,3,4,0. DataMemRd=1 in MEM and WB. ALUM2Reg=1 and RegWre=1 in WB. ALUSrcB=1 and Extsel=1.
- beq with zero=1, then beq with zero=0 → 3 cycles each. PCSrc=1 for the first and 0 for the second in EXE. PCWre=1 both times.
- ori → ALUOp=3, Extsel=0, RegOut=0. Opcode 000111 → IllegalOp pulse in ID, PCWre=1, back to IF after 2 cycles.
- halt → Halted=1 and stays for 10 cycles with all strobes 0. Reset releases the FSM to IF with InstrCount=0.
- CNTW=4 with 16 add instructions → InstrCount wraps from 15 to 0. Reset asserted in the MEM cycle of sw → DataMemWr=0 in that cycle and State=0 after the edge.
